// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared FIR constants. The address generator and the MAC/accumulator block
// both import this package, so they agree on the tap count, the widths and
// the tap index width.
//   DATA_W / COEF_W : signed sample / coefficient widths
//   TAPS            : taps per output sample (tap index 0..TAPS-1)
//   OUT_W / SHIFT   : signed output width, right shift before output
//   TAP_W           : tap index width on the address bus
//   PROD_W / ACC_W  : product width and overflow-free accumulator width
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 25;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 15;
    localparam int TAP_W  = 8;

    // Summing TAPS full-width products needs ceil(log2(TAPS)) guard bits.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

endpackage

// File: rtl/fir_sat_trunc.sv
// ---------------------------------------------------------------------------
// fir_sat_trunc
// Output conversion for the FIR accumulator: arithmetic right shift by SHIFT
// (floor rounding), then narrowing to OUT_W bits.
// Build option FIR_SAT_EN:
//   defined   -> saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   undefined -> keep the low OUT_W bits (two's-complement wrap)
// Ports:
//   i_sum : signed accumulated sum, ACC_W bits
//   o_y   : signed converted output, OUT_W bits
// ---------------------------------------------------------------------------
module fir_sat_trunc #(
    parameter int ACC_W = fir_pkg::ACC_W,
    parameter int OUT_W = fir_pkg::OUT_W,
    parameter int SHIFT = fir_pkg::SHIFT
) (
    input  logic signed [ACC_W-1:0] i_sum,
    output logic signed [OUT_W-1:0] o_y
);

    logic signed [ACC_W-1:0] w_shift;

    assign w_shift = i_sum >>> SHIFT;

`ifdef FIR_SAT_EN
    // The value fits in OUT_W bits exactly when every bit from the output
    // sign position upwards equals the sign bit.
    logic [ACC_W-OUT_W:0] w_hi;
    logic                 w_in_range;

    assign w_hi       = w_shift[ACC_W-1:OUT_W-1];
    assign w_in_range = (&w_hi) | (~|w_hi);

    always_comb begin
        o_y = w_shift[OUT_W-1:0];
        if (!w_in_range) begin
            o_y = w_shift[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    // Wrap mode simply drops the upper bits.
    logic w_unused_hi;

    assign w_unused_hi = ^w_shift[ACC_W-1:OUT_W];
    assign o_y         = w_shift[OUT_W-1:0];
`endif

endmodule

// File: rtl/fir_mac_accum.sv
// ---------------------------------------------------------------------------
// fir_mac_accum
// Multiply-accumulate back end of a TAPS-tap FIR filter. An external address
// generator walks tap_idx 0..TAPS-1; the data RAM and the coefficient ROM
// return their words one cycle later. This block multiplies each pair, sums
// one frame of TAPS products and emits the shifted, narrowed result.
// Build option FIR_SAT_EN selects saturation instead of wrap on the output
// (handled entirely inside fir_sat_trunc).
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   tap_idx  : tap address issued this cycle
//   data_in  : signed sample for the tap_idx of the previous cycle
//   coef_in  : signed coefficient for the tap_idx of the previous cycle
//   y_out    : signed filtered sample, held between updates
//   y_valid  : one-cycle pulse in the cycle y_out takes a new value
//   tap_err  : sticky, an out-of-range tap_idx was seen (cleared by rst only)
// Timing: tap TAPS-1 presented in cycle t gives y_valid in cycle t+3.
// ---------------------------------------------------------------------------
module fir_mac_accum #(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int COEF_W = fir_pkg::COEF_W,
    parameter int TAPS   = fir_pkg::TAPS,
    parameter int OUT_W  = fir_pkg::OUT_W,
    parameter int SHIFT  = fir_pkg::SHIFT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [fir_pkg::TAP_W-1:0] tap_idx,
    input  logic signed [DATA_W-1:0]  data_in,
    input  logic signed [COEF_W-1:0]  coef_in,
    output logic signed [OUT_W-1:0]   y_out,
    output logic                      y_valid,
    output logic                      tap_err
);

    import fir_pkg::*;

    localparam int              PROD_W   = DATA_W + COEF_W;
    localparam int              ACC_W    = acc_width(DATA_W, COEF_W, TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic [TAP_W-1:0] NUM_TAPS = TAP_W'(TAPS);

    // Pipeline registers. r_v_q / r_v_q2 mark slots carrying a tap that was
    // really captured; after reset the cleared tap registers read as tap 0,
    // and without these bits that would look like the start of a frame.
    logic [TAP_W-1:0]         r_tap_q;
    logic [TAP_W-1:0]         r_tap_q2;
    logic                     r_v_q;
    logic                     r_v_q2;
    logic signed [PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [OUT_W-1:0]  r_y_out;
    logic                     r_y_valid;
    logic                     r_tap_err;
    logic                     r_frame_ok;

    logic                     w_tap_ok;
    logic                     w_first;
    logic                     w_last;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [OUT_W-1:0]  w_y;

    assign w_tap_ok   = (r_tap_q < NUM_TAPS);
    assign w_first    = r_v_q2 && (r_tap_q2 == '0);
    assign w_last     = r_v_q2 && (r_tap_q2 == LAST_TAP);
    assign w_prod_ext = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};

    // Tap 0 restarts the sum; this also discards any partial frame when the
    // address generator jumps back early.
    assign w_sum = w_first ? w_prod_ext : (r_acc + w_prod_ext);

    fir_sat_trunc #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_trunc (
        .i_sum (w_sum),
        .o_y   (w_y)
    );

    // Address alignment: tap_idx is registered once to meet its RAM/ROM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tap_q <= '0;
            r_v_q   <= 1'b0;
        end else begin
            r_tap_q <= tap_idx;
            r_v_q   <= 1'b1;
        end
    end

    // Stage 1: multiply. Out-of-range taps contribute zero and flag an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod    <= '0;
            r_tap_q2  <= '0;
            r_v_q2    <= 1'b0;
            r_tap_err <= 1'b0;
        end else begin
            r_tap_q2 <= r_tap_q;
            r_v_q2   <= r_v_q;
            if (r_v_q && w_tap_ok) begin
                r_prod <= data_in * coef_in;
            end else begin
                r_prod <= '0;
            end
            if (r_v_q && !w_tap_ok) begin
                r_tap_err <= 1'b1;
            end
        end
    end

    // Stage 2: accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_v_q2) begin
            r_acc <= w_sum;
        end
    end

    // Frame gate: set once a frame has begun at tap 0, so a frame that was
    // entered part-way through (after reset) never reaches the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_ok <= 1'b0;
        end else if (w_first) begin
            r_frame_ok <= 1'b1;
        end
    end

    // Output register; the gate includes w_first so a single-tap frame works.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_out   <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= w_last && (r_frame_ok || w_first);
            if (w_last && (r_frame_ok || w_first)) begin
                r_y_out <= w_y;
            end
        end
    end

    assign y_out   = r_y_out;
    assign y_valid = r_y_valid;
    assign tap_err = r_tap_err;

endmodule

// File: tb/tb_fir_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_accum
// Drives tap frames (directed and random) into fir_mac_accum and compares
// every cycle against a frame-level reference: each frame's output is the
// sum of the products since the last tap 0, shifted and narrowed, expected
// three cycles after tap TAPS-1 is presented. Directed frames additionally
// carry hand-computed constants. Define FIR_SAT_EN for the saturating build.
// ---------------------------------------------------------------------------
module tb_fir_mac_accum;

    import fir_pkg::*;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [TAP_W-1:0]  tap_idx = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [COEF_W-1:0] coef_in = '0;
    logic [OUT_W-1:0]  y_out;
    logic              y_valid;
    logic              tap_err;
    int                cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_accum dut (
        .clk     (clk),
        .rst     (rst),
        .tap_idx (tap_idx),
        .data_in (data_in),
        .coef_in (coef_in),
        .y_out   (y_out),
        .y_valid (y_valid),
        .tap_err (tap_err)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int NEVER = 32'h7fff_ffff;

    logic [OUT_W-1:0] exp_q[$];      // model outputs in order
    int               exp_cyc_q[$];  // cycle each output is due
    logic [OUT_W-1:0] dir_q[$];      // hand-computed values for directed frames
    bit               in_frame  = 1'b0;
    longint           frame_sum = 0;
    int               err_from  = NEVER;
    logic [OUT_W-1:0] last_y    = '0;

    function automatic logic [OUT_W-1:0] model_conv(input longint s);
        longint q;
        longint hi;
        longint lo;
        q  = s >>> SHIFT;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
`ifdef FIR_SAT_EN
        if (q > hi) q = hi;
        else if (q < lo) q = lo;
`else
        if (hi < lo) q = 0;  // never taken; keeps hi/lo meaningful in both builds
`endif
        return q[OUT_W-1:0];
    endfunction

    task automatic model_reset();
        in_frame  = 1'b0;
        frame_sum = 0;
        err_from  = NEVER;
        last_y    = '0;
        exp_q.delete();
        exp_cyc_q.delete();
        dir_q.delete();
    endtask

    // A captured slot: tap presented in cycle t with its data/coef.
    task automatic model_accept(input int tap, input logic [DATA_W-1:0] d,
                                input logic [COEF_W-1:0] c, input int t);
        longint p;
        p = (tap < TAPS) ? longint'($signed(d)) * longint'($signed(c)) : 64'sd0;
        if (tap >= TAPS && err_from > t + 2) err_from = t + 2;
        if (tap == 0) begin
            frame_sum = 0;
            in_frame  = 1'b1;
        end
        frame_sum += p;
        if (tap == TAPS - 1 && in_frame) begin
            exp_q.push_back(model_conv(frame_sum));
            exp_cyc_q.push_back(t + 3);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic exp_v;

    always @(negedge clk) begin
        exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
        check_eq("y_valid", y_valid, exp_v);
        if (exp_v) begin
            last_y = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
            if (dir_q.size() > 0) check_eq("y_directed", y_out, dir_q.pop_front());
        end
        check_eq("y_out", y_out, last_y);
        check_eq("tap_err", tap_err, (cyc >= err_from));
    end

    // ---------------- driver ----------------
    bit                p_valid = 1'b0;
    int                p_tap   = 0;
    logic [DATA_W-1:0] p_d     = '0;
    logic [COEF_W-1:0] p_c     = '0;
    int                p_cyc   = 0;

    // Presents one tap per cycle; its data/coef follow one cycle later.
    task automatic drive_slot(input int tap, input logic [DATA_W-1:0] d,
                              input logic [COEF_W-1:0] c);
        @(posedge clk);
        if (p_valid && !rst) model_accept(p_tap, p_d, p_c, p_cyc);
        #1;
        tap_idx = TAP_W'(tap);
        data_in = p_d;
        coef_in = p_c;
        p_valid = 1'b1;
        p_tap   = tap;
        p_d     = d;
        p_c     = c;
        p_cyc   = cyc;
    endtask

    task automatic frame_const(input logic [DATA_W-1:0] d, input logic [COEF_W-1:0] c);
        for (int t = 0; t < TAPS; t++) drive_slot(t, d, c);
    endtask

    task automatic frame_rand();
        for (int t = 0; t < TAPS; t++) drive_slot(t, DATA_W'($urandom), COEF_W'($urandom));
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_y_out", y_out, 0);
        check_eq("rst_y_valid", y_valid, 0);
        check_eq("rst_tap_err", tap_err, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Power-up reset, released mid-cycle.
        #1;
        assert_reset();
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // 0x4000 * 2 over 25 taps -> 25
        for (int k = 0; k < 3; k++) dir_q.push_back(16'h0019);
        repeat (3) frame_const(16'h4000, 16'h0002);

        // 0xC000 * 2 -> -25
        for (int k = 0; k < 2; k++) dir_q.push_back(16'hFFE7);
        repeat (2) frame_const(16'hC000, 16'h0002);

        // Largest positive product on every tap
`ifdef FIR_SAT_EN
        dir_q.push_back(16'h7FFF);
`else
        dir_q.push_back(16'h7FCE);
`endif
        frame_const(16'h7FFF, 16'h7FFF);

        // Random frames
        repeat (4) frame_rand();

        // Early jump back to tap 0: partial frame discarded
        for (int t = 0; t < 10; t++) drive_slot(t, DATA_W'($urandom), COEF_W'($urandom));
        dir_q.push_back(16'h0019);
        frame_const(16'h4000, 16'h0002);

        // Out-of-range tap 30 in place of tap 5 -> 24, then 25; tap_err sticky
        dir_q.push_back(16'h0018);
        dir_q.push_back(16'h0019);
        for (int t = 0; t < TAPS; t++) drive_slot((t == 5) ? 30 : t, 16'h4000, 16'h0002);
        frame_const(16'h4000, 16'h0002);
        frame_rand();

        // Reset pulsed at tap 10, released mid-clock two cycles later
        for (int t = 0; t <= 10; t++) drive_slot(t, 16'h4000, 16'h0002);
        fork
            begin
                #2 assert_reset();
                #24 rst = 1'b0;
            end
        join_none
        for (int t = 11; t < TAPS; t++) drive_slot(t, 16'h4000, 16'h0002);
        dir_q.push_back(16'h0019);
        frame_const(16'h4000, 16'h0002);

        // Reset held from tap 0, released while tap 12 is presented
        drive_slot(0, 16'h4000, 16'h0002);
        fork
            begin
                #2 assert_reset();
                #119 rst = 1'b0;
            end
        join_none
        for (int t = 1; t < TAPS; t++) drive_slot(t, 16'h4000, 16'h0002);
        dir_q.push_back(16'h0019);
        frame_const(16'h4000, 16'h0002);
        frame_rand();

        // Drain: a short partial frame, then every expected output must be out
        for (int t = 0; t < 6; t++) drive_slot(t, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        check_eq("drain_outputs", exp_q.size(), 0);
        check_eq("drain_directed", dir_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
